// File: rtl/mac_chunk_sequencer.sv
// Chunk sequencer for a 16-lane MAC: issues NUM_CHUNKS memory reads, tracks
// pipeline validity, accumulates per-chunk sums and adds a bias to form one neuron result.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | driving addresses 0..NUM_CHUNKS-1, one per cycle
// DRAIN | reads finished, waiting for the last sums to leave the pipe
// DONE  | one-cycle done pulse, result valid
module mac_chunk_sequencer #(
  parameter int NUM_CHUNKS = 49,
  parameter int ADDR_WIDTH = 6,
  parameter int PIPE_LAT   = 4,
  parameter int SUM_WIDTH  = 20,
  parameter int ACC_WIDTH  = 26
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ACC_WIDTH-1:0]  bias,
  input  logic [SUM_WIDTH-1:0]  mac_sum,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_CHUNKS - 1);

  state_t                state;
  logic [PIPE_LAT-1:0]   vpipe;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ADDR_WIDTH-1:0] acc_cnt;
  logic                  tail;
  logic [ACC_WIDTH-1:0]  sum_ext;

  // The pipe tail marks the cycle in which mac_sum belongs to an issued read.
  assign tail    = vpipe[PIPE_LAT-1];
  assign sum_ext = ACC_WIDTH'(mac_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      acc       <= '0;
      acc_cnt   <= '0;
      vpipe     <= '0;
    end else begin
      vpipe <= PIPE_LAT'({vpipe, mem_rd_en});
      done  <= 1'b0;
      if (tail) begin
        acc     <= acc + sum_ext;
        acc_cnt <= acc_cnt + ADDR_WIDTH'(1);
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= ISSUE;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
            busy      <= 1'b1;
            acc       <= '0;
            acc_cnt   <= '0;
            vpipe     <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ISSUE: begin
          // mem_addr doubles as the issue counter and holds after the last read.
          if (mem_addr == LAST) begin
            state     <= DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (tail && acc_cnt == LAST) begin
            result <= acc + sum_ext + bias;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_chunk_sequencer.sv
// Bench for mac_chunk_sequencer: three instances (49, 4 and 1 chunks) fed by a
// behavioural memory+MAC model; results and cycle timing checked against the latency rules.
module tb_mac_chunk_sequencer;

  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [3];
  logic [25:0] bias_s  [3];
  logic [19:0] msum    [3];
  logic        en_w    [3];
  logic [5:0]  addr_w  [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic [25:0] res_w   [3];

  int checks = 0;
  int errors = 0;

  logic [19:0] tbl      [3][64];
  logic [25:0] prev_res [3];
  logic        hist_en  [3][PL+1] = '{default: 1'b0};
  logic [5:0]  hist_ad  [3][PL+1] = '{default: 6'd0};
  int          ns       [3] = '{49, 4, 1};

  typedef struct {
    int          d;
    int          n;
    int          mode;
    logic [25:0] b;
    logic [25:0] exp_res;
    int          exp_done;
  } vec_t;

  vec_t vecs [3];

  always #5 clk = ~clk;

  mac_chunk_sequencer #(.NUM_CHUNKS(49)) u_n49 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .bias(bias_s[0]), .mac_sum(msum[0]),
    .mem_rd_en(en_w[0]), .mem_addr(addr_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .result(res_w[0]));

  mac_chunk_sequencer #(.NUM_CHUNKS(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .bias(bias_s[1]), .mac_sum(msum[1]),
    .mem_rd_en(en_w[1]), .mem_addr(addr_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .result(res_w[1]));

  mac_chunk_sequencer #(.NUM_CHUNKS(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .bias(bias_s[2]), .mac_sum(msum[2]),
    .mem_rd_en(en_w[2]), .mem_addr(addr_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .result(res_w[2]));

  // Memory + 3-stage MAC: the sum for a read issued in cycle a is presented in cycle a+PL.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      for (int i = PL; i > 0; i--) begin
        hist_en[d][i] = hist_en[d][i-1];
        hist_ad[d][i] = hist_ad[d][i-1];
      end
      hist_en[d][0] = en_w[d];
      hist_ad[d][0] = addr_w[d];
      msum[d] = hist_en[d][PL] ? tbl[d][hist_ad[d][PL]] : 20'($urandom);
    end
  end

  task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input int d, input string nm);
    chk(d, {nm, "_rd_en"},  64'(en_w[d]),   64'd0);
    chk(d, {nm, "_addr"},   64'(addr_w[d]), 64'd0);
    chk(d, {nm, "_busy"},   64'(busy_w[d]), 64'd0);
    chk(d, {nm, "_done"},   64'(done_w[d]), 64'd0);
    chk(d, {nm, "_result"}, 64'(res_w[d]),  64'd0);
  endtask

  function automatic logic [25:0] model_res(input int d, input int n, input logic [25:0] b);
    logic [31:0] s;
    s = 32'(b);
    for (int k = 0; k < n; k++) s = s + 32'(tbl[d][k]);
    return s[25:0];
  endfunction

  // Called at a negedge: that cycle is c0, the cycle whose closing edge samples start.
  task automatic run(input int d, input int n, input logic [25:0] b, input logic [25:0] exp,
                     input int dc, input bit hold);
    start_s[d] = 1'b1;
    bias_s[d]  = 26'($urandom);
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start_s[d] = 1'b0;
      chk(d, "rd_en",  64'(en_w[d]),   64'(c <= n));
      chk(d, "addr",   64'(addr_w[d]), 64'((c <= n) ? c - 1 : n - 1));
      chk(d, "busy",   64'(busy_w[d]), 64'(c < dc));
      chk(d, "done",   64'(done_w[d]), 64'(c == dc));
      chk(d, "result", 64'(res_w[d]),  64'((c == dc) ? exp : prev_res[d]));
      bias_s[d] = (c == dc - 1) ? b : 26'($urandom);
    end
    prev_res[d] = exp;
  endtask

  initial begin
    logic        seen_done;
    logic        seen_res;
    logic [25:0] b;
    int          gap;

    vecs[0] = '{d: 0, n: 49, mode: 0, b: 26'd0,        exp_res: 26'd51380175, exp_done: 54};
    vecs[1] = '{d: 1, n: 4,  mode: 1, b: 26'd67108859, exp_res: 26'd5,        exp_done: 9};
    vecs[2] = '{d: 2, n: 1,  mode: 2, b: 26'd3,        exp_res: 26'd10,       exp_done: 6};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_s[d]  = 1'b0;
      bias_s[d]   = '0;
      prev_res[d] = '0;
      for (int k = 0; k < 64; k++) tbl[d][k] = '0;
    end

    // Reset held while start toggles.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk_zero(d, "rst_hold");
        start_s[d] = (c % 2 == 0);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
    rst_n = 1'b1;

    // Directed table vectors.
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 64; k++)
        tbl[vecs[v].d][k] = (vecs[v].mode == 0) ? 20'hFFFFF :
                            (vecs[v].mode == 1) ? 20'(k + 1) : 20'd7;
      repeat (2) @(negedge clk);
      run(vecs[v].d, vecs[v].n, vecs[v].b, vecs[v].exp_res, vecs[v].exp_done, 1'b0);
    end

    // start held through a whole run, then an immediate back-to-back run.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 64; k++) tbl[0][k] = 20'(k * 3 + 1);
    b = 26'd1000;
    run(0, 49, b, model_res(0, 49, b), 54, 1'b1);
    for (int k = 0; k < 64; k++) tbl[0][k] = 20'(1000 + k);
    b = 26'd17;
    run(0, 49, b, model_res(0, 49, b), 54, 1'b0);

    // Asynchronous reset in the middle of a run.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 64; k++) tbl[0][k] = 20'd5;
    start_s[0] = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) start_s[0] = 1'b0;
    end
    chk(0, "mid_addr",  64'(addr_w[0]), 64'd20);
    chk(0, "mid_rd_en", 64'(en_w[0]),   64'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk_zero(d, "async_rst");
      prev_res[d] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    seen_res  = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done_w[0]) seen_done = 1'b1;
      if (res_w[0] != 26'd0) seen_res = 1'b1;
    end
    chk(0, "no_done_after_rst", 64'(seen_done), 64'd0);
    chk(0, "result_after_rst",  64'(seen_res),  64'd0);
    b = 26'd9;
    run(0, 49, b, model_res(0, 49, b), 54, 1'b0);

    // Random tables, biases and gaps against the reference model.
    for (int r = 0; r < 9; r++) begin
      int d;
      d = r % 3;
      for (int k = 0; k < 64; k++) tbl[d][k] = 20'($urandom);
      b   = 26'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk(d, "gap_busy", 64'(busy_w[d]), 64'd0);
        chk(d, "gap_done", 64'(done_w[d]), 64'd0);
      end
      run(d, ns[d], b, model_res(d, ns[d], b), ns[d] + PL + 1, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
